bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Outputs change only on completion; out-of-range inputs saturate or wrap per SATURATE.
module bin2bcd_seq #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_ITER = 4'd14;
    localparam logic [13:0] MAX_BCD   = 14'd9999;
    localparam logic [15:0] ALL_NINES = 16'h9999;

    state_t      state_q, state_d;
    logic [13:0] shreg_q, shreg_d;
    logic [19:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] digits_q, digits_d;
    logic        ovf_q, ovf_d;
    logic [19:0] adj;

    // Add 3 to every nibble >= 5 so the following left shift carries into the next decade.
    function automatic logic [19:0] add3_nibbles(input logic [19:0] s);
        logic [19:0] r;
        logic [3:0]  nib;
        r = s;
        for (int i = 0; i < 5; i++) begin
            nib = s[i*4 +: 4];
            if (nib >= 4'd5) begin
                r[i*4 +: 4] = nib + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] final_digits(input logic [19:0] s, input logic out_of_range);
        logic [15:0] r;
        if (SATURATE && out_of_range) begin
            r = ALL_NINES;
        end else begin
            r = s[15:0];
        end
        return r;
    endfunction

    always_comb begin
        adj = add3_nibbles(scratch_q);
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (bin > MAX_BCD);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // After 14 shifts the scratch holds the full BCD result; publish it in one step.
                if (cnt_q == LAST_ITER) begin
                    digits_d = final_digits(scratch_q, ovf_pend_q);
                    ovf_d    = ovf_pend_q;
                    state_d  = DONE;
                end else begin
                    {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                    cnt_d                = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign ovf  = ovf_q;
    assign d1   = digits_q[3:0];
    assign d2   = digits_q[7:4];
    assign d3   = digits_q[11:8];
    assign d4   = digits_q[15:12];

endmodule
